// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) and divide (restoring) unit
// that owns HI/LO; one iteration per clock, then a sign-fix/writeback cycle and a done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multControl,
  input  logic             divControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2*WIDTH:0] r_p;
  logic [WIDTH-1:0] r_m, r_rem, r_quo;
  logic             r_is_div, r_neg_q, r_neg_r;
  logic [WIDTH:0]   w_acc, w_m, w_sum, w_shift;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_diff, w_q_fix, w_r_fix;
  logic             w_ge;
  // Booth accumulator is widened by one bit so subtracting MIN cannot overflow before the shift
  always_comb begin
    w_acc   = {r_p[2*WIDTH], r_p[2*WIDTH:WIDTH+1]};
    w_m     = {r_m[WIDTH-1], r_m};
    w_sum   = (r_p[1:0] == 2'b01) ? w_acc + w_m : (r_p[1:0] == 2'b10) ? w_acc - w_m : w_acc;
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_ge    = w_shift >= {1'b0, r_m};
    w_diff  = w_shift[WIDTH-1:0] - r_m;
    w_abs_a = a[WIDTH-1] ? -a : a;
    w_abs_b = b[WIDTH-1] ? -b : b;
    w_q_fix = r_neg_q ? -r_quo : r_quo;
    w_r_fix = r_neg_r ? -r_rem : r_rem;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      divZero  <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (multControl) begin
            r_state  <= MULT;
            busy     <= 1'b1;
            r_is_div <= 1'b0;
            r_m      <= a;
            r_p      <= {{WIDTH{1'b0}}, b, 1'b0};
            r_cnt    <= CW'(WIDTH - 1);
          end else if (divControl && b == '0) begin
            divZero <= 1'b1;
          end else if (divControl) begin
            r_state  <= DIV;
            busy     <= 1'b1;
            r_is_div <= 1'b1;
            r_m      <= w_abs_b;
            r_quo    <= w_abs_a;
            r_rem    <= '0;
            r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r  <= a[WIDTH-1];
            r_cnt    <= CW'(WIDTH - 1);
          end
        end
        MULT: begin
          r_p   <= {w_sum, r_p[WIDTH:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        DIV: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= FIX;
        end
        FIX: begin
          hi      <= r_is_div ? w_r_fix : r_p[2*WIDTH:WIDTH+1];
          lo      <= r_is_div ? w_q_fix : r_p[WIDTH:1];
          done    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
  logic        clk = 0, reset = 1;
  logic        mc32 = 0, dc32 = 0, mc8 = 0, dc8 = 0;
  logic [31:0] a32 = 0, b32 = 0, hi32, lo32;
  logic [7:0]  a8 = 0, b8 = 0, hi8, lo8;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  int          n_chk = 0, n_fail = 0;
  typedef struct {bit dz; longint h; longint l;} exp_t;
  exp_t        q32[$], q8[$];
  exp_t        e32, e8;
  longint      mh[2], ml[2];
  logic [31:0] corners[5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .multControl(mc32), .divControl(dc32), .a(a32), .b(b32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .divZero(dz32));
  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .multControl(mc8), .divControl(dc8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .divZero(dz8));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Plain signed arithmetic on sign-extended operands; SV / and % truncate toward zero.
  function automatic void model(input bit m, input longint x, input longint y, input int w,
                                output longint h, output longint l);
    longint sx, sy, p, mask;
    mask = (longint'(1) << w) - 1;
    sx = (x << (64 - w)) >>> (64 - w);
    sy = (y << (64 - w)) >>> (64 - w);
    if (m) begin
      p = sx * sy;
      h = (p >>> w) & mask;
      l = p & mask;
    end else begin
      h = (sx % sy) & mask;
      l = (sx / sy) & mask;
    end
  endfunction

  always @(negedge clk) if (done32 || dz32) begin
    n_chk++;
    if (q32.size() == 0) begin
      n_fail++;
      $display("FAIL w32 unexpected event: done=%0b divZero=%0b", done32, dz32);
    end else begin
      e32 = q32.pop_front();
      if (done32 !== !e32.dz || dz32 !== e32.dz || hi32 !== e32.h[31:0] || lo32 !== e32.l[31:0]) begin
        n_fail++;
        $display("FAIL w32 result: done=%0b divZero=%0b hi=%h lo=%h expected done=%0b divZero=%0b hi=%h lo=%h",
                 done32, dz32, hi32, lo32, !e32.dz, e32.dz, e32.h[31:0], e32.l[31:0]);
      end
    end
  end

  always @(negedge clk) if (done8 || dz8) begin
    n_chk++;
    if (q8.size() == 0) begin
      n_fail++;
      $display("FAIL w8 unexpected event: done=%0b divZero=%0b", done8, dz8);
    end else begin
      e8 = q8.pop_front();
      if (done8 !== !e8.dz || dz8 !== e8.dz || hi8 !== e8.h[7:0] || lo8 !== e8.l[7:0]) begin
        n_fail++;
        $display("FAIL w8 result: done=%0b divZero=%0b hi=%h lo=%h expected done=%0b divZero=%0b hi=%h lo=%h",
                 done8, dz8, hi8, lo8, !e8.dz, e8.dz, e8.h[7:0], e8.l[7:0]);
      end
    end
  end

  task automatic do_op(input bit s, input bit m, input bit d, input logic [31:0] x, input logic [31:0] y);
    int w = s ? 8 : 32;
    bit zero;
    longint h, l;
    exp_t e;
    int k, lat, bc;
    zero = s ? (y[7:0] == 0) : (y == 0);
    if (m || !zero) begin
      model(m, longint'(x), longint'(y), w, h, l);
      e.dz = 0; e.h = h; e.l = l;
      mh[s] = h; ml[s] = l;
    end else begin
      e.dz = 1; e.h = mh[s]; e.l = ml[s];
    end
    if (s) q8.push_back(e); else q32.push_back(e);
    @(negedge clk);
    if (s) begin mc8 = m; dc8 = d; a8 = x[7:0]; b8 = y[7:0]; end
    else begin mc32 = m; dc32 = d; a32 = x; b32 = y; end
    @(posedge clk); #1;
    mc8 = 0; dc8 = 0; mc32 = 0; dc32 = 0;
    a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    if (e.dz) begin
      chk("divZero pulse", s ? dz8 : dz32, 1);
      chk("busy on divZero", s ? busy8 : busy32, 0);
      @(posedge clk); #1;
      chk("divZero one cycle", s ? dz8 : dz32, 0);
      chk("busy after divZero", s ? busy8 : busy32, 0);
      chk("hi held", s ? hi8 : hi32, e.h);
      chk("lo held", s ? lo8 : lo32, e.l);
    end else begin
      k = 0; lat = -1; bc = int'(s ? busy8 : busy32);
      while ((s ? busy8 : busy32) && k < 200) begin
        @(posedge clk); #1;
        k++;
        if (s ? done8 : done32) lat = k;
        bc += int'(s ? busy8 : busy32);
      end
      chk("latency", lat, w + 1);
      chk("busy cycles", bc, w + 2);
      chk("hi", s ? hi8 : hi32, h);
      chk("lo", s ? lo8 : lo32, l);
    end
  endtask

  initial begin
    logic [31:0] x, y;
    bit s, m, d;
    mh = '{0, 0}; ml = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst hi32", hi32, 0); chk("rst lo32", lo32, 0); chk("rst busy32", busy32, 0);
    chk("rst done32", done32, 0); chk("rst dz32", dz32, 0);
    chk("rst hi8", hi8, 0); chk("rst lo8", lo8, 0); chk("rst busy8", busy8, 0);
    reset = 0;
    do_op(0, 1, 0, 32'd7, 32'hFFFFFFFD);
    chk("7*-3 hi", hi32, 64'hFFFFFFFF); chk("7*-3 lo", lo32, 64'hFFFFFFEB);
    do_op(0, 1, 0, 32'h80000000, 32'h80000000);
    chk("min*min hi", hi32, 64'h40000000); chk("min*min lo", lo32, 0);
    do_op(0, 1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("max*max hi", hi32, 64'h3FFFFFFF); chk("max*max lo", lo32, 1);
    do_op(0, 0, 1, 32'hFFFFFFF9, 32'd2);
    chk("-7/2 lo", lo32, 64'hFFFFFFFD); chk("-7/2 hi", hi32, 64'hFFFFFFFF);
    do_op(0, 0, 1, 32'h80000000, 32'hFFFFFFFF);
    chk("min/-1 lo", lo32, 64'h80000000); chk("min/-1 hi", hi32, 0);
    do_op(0, 1, 0, 32'h33333333, 32'h55555556);
    chk("preload hi", hi32, 64'h11111111); chk("preload lo", lo32, 64'h22222222);
    do_op(0, 0, 1, 32'd5, 32'd0);
    chk("div0 hi", hi32, 64'h11111111); chk("div0 lo", lo32, 64'h22222222);
    do_op(1, 1, 0, 32'h7F, 32'h7F);
    chk("w8 max*max hi", hi8, 64'h3F); chk("w8 max*max lo", lo8, 64'h01);
    do_op(1, 0, 1, 32'h80, 32'h03);
    chk("w8 -128/3 lo", lo8, 64'hD6); chk("w8 -128/3 hi", hi8, 64'hFE);
    // abort a multiply by reset after stray starts mid-run
    @(negedge clk); mc32 = 1; a32 = 32'd123; b32 = 32'd456;
    @(posedge clk); #1; mc32 = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); mc32 = 1; dc32 = 1; b32 = 0;
    @(posedge clk); #1; mc32 = 0; dc32 = 0;
    chk("busy through ignored start", busy32, 1);
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1; reset = 0;
    mh = '{0, 0}; ml = '{0, 0};
    chk("abort hi", hi32, 0); chk("abort lo", lo32, 0);
    chk("abort busy", busy32, 0); chk("abort done", done32, 0); chk("abort hi8", hi8, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("no done after abort", done32, 0);
    do_op(0, 1, 1, 32'hFFFFFF00, 32'd9);
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      d = m ? ($urandom_range(0, 3) == 0) : 1'b1;
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      do_op(s, m, d, x, y);
    end
    repeat (5) @(posedge clk);
    chk("w32 queue drained", q32.size(), 0);
    chk("w8 queue drained", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit that owns the HI and LO registers of the MIPS datapath. It is started by the control unit through `multControl` / `divControl` and computes signed products (HI:LO) or signed quotient/remainder (LO/HI) over WIDTH iterations. It raises a one-cycle `divZero` flag that the control unit uses to select the divide-by-zero exception vector.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; any value ≥ 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- multControl  in  1  start signed multiply; sampled in IDLE only
- divControl  in  1  start signed divide; sampled in IDLE only
- a  in  WIDTH  operand A (multiplicand / dividend)
- b  in  WIDTH  operand B (multiplier / divisor)
- hi  out  WIDTH  HI register: product upper half / remainder
- lo  out  WIDTH  LO register: product lower half / quotient
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; hi/lo hold the new result in this cycle
- divZero  out  1  one-cycle pulse; divide requested with b = 0

## Operation
- States:
  - IDLE
  - MULT: WIDTH iterations.
  - DIV: WIDTH iterations.
  - FIX: one cycle for sign correction and writeback.
  - DONE: one cycle.
- IDLE:
  - multControl=1 → latch a, b; counter ← WIDTH−1; go to MULT.
  - Else divControl=1 and b≠0 → latch a, b; go to DIV.
  - Else divControl=1 and b=0 → divZero=1 next cycle; stay IDLE; hi/lo unchanged; done not asserted.
  - multControl and divControl both high → multiply wins; the divide is dropped.
- Starts arriving in MULT, DIV, FIX or DONE are ignored, with no queueing.
- MULT:
  - Radix-2 Booth on a 2·WIDTH+1-bit product register: one add/sub plus an arithmetic right shift per cycle.
  - Counter decrements each cycle; at 0 go to FIX.
- DIV:
  - Restoring divide on operand magnitudes; one quotient bit per cycle.
  - Counter decrements each cycle; at 0 go to FIX.
- FIX:
  - Multiply: the result is used as is.
  - Divide: quotient negated if sign(a)≠sign(b); remainder carries the sign of a. Quotient truncates toward zero.
  - Write hi/lo at the FIX→DONE edge.
- DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic rules:
  - Product is the full 2·WIDTH-bit signed result; no overflow is possible.
  - MIN/−1: lo=MIN, hi=0. Wraps naturally, with no flag.
- hi/lo change only at the FIX→DONE edge or on reset; they hold their value otherwise, including across divZero.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, divZero=0; state=IDLE; counter=0.
- Reset mid-operation aborts at the next edge: state IDLE, hi/lo cleared, no done pulse.
- Start is sampled at edge E0. busy=1 from the cycle after E0.
- Iterations occur at edges E1…E_WIDTH. FIX is active in the cycle after E_WIDTH.
- hi/lo are written and done rises after edge E_WIDTH+1.
- Latency is WIDTH+1 clocks from the start edge to done high, identical for mult and div.
- busy falls with the DONE→IDLE edge. A new start is accepted in the first IDLE cycle after done.
- divZero is registered: high the cycle after E0, for one cycle; busy stays 0.
- Operand inputs may change freely after E0 because they are latched internally.
- done, divZero and busy are driven directly from flops.

## Test plan
- WIDTH=32, mult a=7, b=0xFFFFFFFD (−3) → done 33 clocks after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 34 cycles.
- WIDTH=32, mult a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0x7FFFFFFF, b=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- WIDTH=32, div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi/lo=0x11111111/0x22222222, then div a=5, b=0 → divZero high exactly one cycle after start; done never asserted; busy stays 0; hi/lo unchanged.
- Start mult; pulse divControl and multControl mid-run; assert reset at iteration 10 → ignored starts have no effect; after reset hi=lo=0, busy=0, no done pulse. Then start a multiply and a divide together → only the multiply executes.
- WIDTH=8, mult a=0x7F, b=0x7F → hi=0x3F, lo=0x01, done 9 clocks after start. Also div a=0x80, b=0x03 → lo=0xD6, hi=0xFE.
